// File: rtl/mac_stream_acc.sv
// mac_stream_acc: pipelined multiply-accumulate lane producing one dot product per in_last-delimited vector
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        operand stream handshake; in_ready = !res_valid || res_ready
//   a_i, b_i, in_last        operand pair and end-of-vector marker
//   res_valid/res_ready      result stream handshake with backpressure
//   res_data, res_ovf        completed dot product and its sticky overflow flag
//   acc_o                    running accumulator (0 right after a vector completes)
module mac_stream_acc #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 32,
  parameter bit A_SIGNED = 1'b1,
  parameter bit B_SIGNED = 1'b0,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  output logic [ACC_W-1:0] acc_o
);
  localparam int PW = A_W + B_W;
  localparam bit RS = A_SIGNED || B_SIGNED;

  if (ACC_W < PW) begin : g_width_chk
    $error("mac_stream_acc: ACC_W must be >= A_W+B_W");
  end

  logic             en, ovf, done;
  logic [PW-1:0]    a_x, b_x, prod;
  logic [ACC_W-1:0] p_ext, base, sum, sat_v;
  logic [ACC_W:0]   sum_w;
  logic             p_vld_q, p_vld_d, p_last_q, p_last_d;
  logic [PW-1:0]    p_q, p_d;
  logic [ACC_W-1:0] acc_q, acc_d, res_data_q, res_data_d;
  logic             first_q, first_d, ovf_acc_q, ovf_acc_d;
  logic             res_valid_q, res_valid_d, res_ovf_q, res_ovf_d;

  always_comb begin
    en    = !res_valid_q || res_ready;
    // Each operand is extended by its own signedness; the PW-bit product is exact either way.
    a_x   = A_SIGNED ? PW'($signed(a_i)) : PW'(a_i);
    b_x   = B_SIGNED ? PW'($signed(b_i)) : PW'(b_i);
    prod  = a_x * b_x;
    p_ext = RS ? ACC_W'($signed(p_q)) : ACC_W'(p_q);
    // The first pair of a vector ignores whatever is left in acc_q.
    base  = first_q ? '0 : acc_q;
    sum_w = RS ? {base[ACC_W-1], base} + {p_ext[ACC_W-1], p_ext} : {1'b0, base} + {1'b0, p_ext};
    ovf   = RS ? (sum_w[ACC_W] != sum_w[ACC_W-1]) : sum_w[ACC_W];
    // sum_w[ACC_W] is the true sign of the signed sum, so it picks min vs max on overflow.
    sat_v = RS ? {sum_w[ACC_W], {(ACC_W-1){~sum_w[ACC_W]}}} : '1;
    sum   = (SATURATE && ovf) ? sat_v : sum_w[ACC_W-1:0];
    done  = en && p_vld_q && p_last_q;
    p_vld_d    = p_vld_q;
    p_last_d   = p_last_q;
    p_d        = p_q;
    acc_d      = acc_q;
    first_d    = first_q;
    ovf_acc_d  = ovf_acc_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    if (en) begin
      p_vld_d = in_valid;
      if (in_valid) begin
        p_d      = prod;
        p_last_d = in_last;
      end
    end
    if (en && p_vld_q) begin
      ovf_acc_d = (!first_q && ovf_acc_q) || ovf;
      acc_d     = p_last_q ? '0 : sum;
      first_d   = p_last_q;
    end
    // A new completion in the same cycle as a handshake keeps res_valid high.
    res_valid_d = done || (res_valid_q && !res_ready);
    if (done) begin
      res_data_d = sum;
      res_ovf_d  = ovf_acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld_q     <= 1'b0;
      p_last_q    <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      ovf_acc_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      p_vld_q     <= p_vld_d;
      p_last_q    <= p_last_d;
      p_q         <= p_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      ovf_acc_q   <= ovf_acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign in_ready  = en;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign acc_o     = acc_q;
endmodule

// File: tb/tb_mac_stream_acc.sv
// tb_mac_stream_acc: drives six differently configured lanes with one shared stream and checks each against a per-vector arithmetic model
module tb_mac_stream_acc;
  localparam int NC = 6;
  localparam int CW [NC] = '{32, 16, 16, 32, 32, 16};
  localparam logic [NC-1:0] CA = 6'b010111;
  localparam logic [NC-1:0] CB = 6'b010000;
  localparam logic [NC-1:0] CS = 6'b100010;
  localparam int NL = 14;
  localparam int LR [NL] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 5, 6, 7, 8, 9};
  localparam int LC [NL] = '{0, 3, 4, 0, 0, 1, 2, 0, 3, 4, 0, 0, 0, 0};
  localparam logic [32:0] LV [NL] = '{33'h0FFFFFF01, 33'd65025, 33'd1, 33'd32136, 33'd1,
                                       33'h100007FFF, 33'h10000FD02, 33'd64770, 33'd130050,
                                       33'd16384, 33'd30, 33'd58, 33'd81, 33'd12};

  typedef logic [NC-1:0][32:0] exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, res_ready, last;
  logic [7:0] a, b;
  logic [NC-1:0] rdy, rv, rov;
  logic [NC-1:0][31:0] rd, ac;

  exp_t q[$];
  longint macc [NC];
  bit mov [NC];
  bit mfirst;
  int total = 0, bad = 0, nres = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : gc
    mac_stream_acc #(.A_W(8), .B_W(8), .ACC_W(CW[g]), .A_SIGNED(CA[g]), .B_SIGNED(CB[g]),
                     .SATURATE(CS[g])) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[g]), .a_i(a), .b_i(b),
      .in_last(last), .res_valid(rv[g]), .res_ready(res_ready), .res_data(rd[g][CW[g]-1:0]),
      .res_ovf(rov[g]), .acc_o(ac[g][CW[g]-1:0]));
    if (CW[g] < 32) begin : gz
      assign rd[g][31:CW[g]] = '0;
      assign ac[g][31:CW[g]] = '0;
    end
  end

  task automatic chk(input string n, input int k, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cfg=%0d nres=%0d act=%0h required=%0h t=%0t", n, k, nres, act, exp, $time);
    end
  endtask

  // Mathematical dot-product step: exact sum, range test, then clamp or wrap.
  task automatic step();
    exp_t e;
    longint m, mx, mn, av, bv, s;
    bit rs, o, ov;
    for (int k = 0; k < NC; k++) begin
      rs = CA[k] || CB[k];
      av = CA[k] ? longint'($signed(a)) : longint'(a);
      bv = CB[k] ? longint'($signed(b)) : longint'(b);
      m  = longint'(1) << CW[k];
      mx = rs ? (m >>> 1) - 1 : m - 1;
      mn = rs ? -(m >>> 1) : 0;
      s  = (mfirst ? 0 : macc[k]) + av * bv;
      o  = (s > mx) || (s < mn);
      if (o) begin
        if (CS[k]) s = (s > mx) ? mx : mn;
        else begin
          s = s & (m - 1);
          if (rs && s > mx) s -= m;
        end
      end
      ov = (!mfirst && mov[k]) || o;
      e[k] = {ov, 32'(s & (m - 1))};
      macc[k] = s;
      mov[k] = ov;
    end
    if (last) q.push_back(e);
    mfirst = last;
  endtask

  // Per-cycle compare, sampled on the falling edge; returns whether the pair is taken at the next rising edge.
  task automatic tick(output bit ok);
    exp_t e;
    @(negedge clk);
    ok = 1'b0;
    if (!rst) begin
      q.delete();
      mfirst = 1'b1;
    end else begin
      for (int k = 0; k < NC; k++) chk("in_ready", k, rdy[k], !rv[k] || res_ready);
      for (int k = 1; k < NC; k++) chk("res_valid_lockstep", k, rv[k], rv[0]);
      if (rv[0] && res_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_result nres=%0d act=%0h required=none", nres, rd[0]);
        end else begin
          e = q.pop_front();
          for (int k = 0; k < NC; k++) begin
            chk("res_data", k, rd[k], e[k][31:0]);
            chk("res_ovf", k, rov[k], e[k][32]);
          end
          for (int i = 0; i < NL; i++)
            if (LR[i] == nres) chk("literal", LC[i], {rov[LC[i]], rd[LC[i]]}, LV[i]);
          nres++;
        end
      end
      ok = in_valid && rdy[0];
      if (ok) step();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic sl);
    bit ok;
    int n = 0;
    in_valid = 1'b1;
    a = sa;
    b = sb;
    last = sl;
    do begin
      tick(ok);
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout act=not_accepted required=accepted a=%0h b=%0h", sa, sb);
    end
  endtask

  task automatic idle(input int n);
    bit ok;
    in_valid = 1'b0;
    repeat (n) tick(ok);
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    last = 1'b0;
    a = '0;
    b = '0;
    mfirst = 1'b1;
    repeat (2) tick(ok);
    for (int k = 0; k < NC; k++) begin
      chk("rst_res_valid", k, rv[k], 0);
      chk("rst_res_data", k, rd[k], 0);
      chk("rst_res_ovf", k, rov[k], 0);
      chk("rst_acc_o", k, ac[k], 0);
    end
    rst = 1'b1;
    idle(1);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    last = 1'b1;
    tick(ok);
    chk("single_accept", 0, ok, 1);
    chk("latency_stage_p", 0, rv[0], 0);
    in_valid = 1'b0;
    tick(ok);
    chk("latency_stage_a", 0, rv[0], 1);
    chk("acc_after_last", 0, ac[0], 0);
    idle(3);
    send(8'hFF, 8'hFF, 1'b0);
    send(8'd2, 8'd3, 1'b0);
    send(8'd127, 8'd255, 1'b1);
    send(8'd1, 8'd1, 1'b1);
    idle(4);
    send(8'd127, 8'd255, 1'b0);
    send(8'd127, 8'd255, 1'b1);
    idle(3);
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    send(8'h80, 8'h80, 1'b1);
    idle(4);
    res_ready = 1'b0;
    send(8'd5, 8'd6, 1'b1);
    send(8'd7, 8'd8, 1'b0);
    in_valid = 1'b1;
    a = 8'd1;
    b = 8'd2;
    last = 1'b1;
    repeat (5) begin
      chk("hold_in_ready", 0, rdy[0], 0);
      chk("hold_res_valid", 0, rv[0], 1);
      tick(ok);
      chk("hold_no_accept", 0, ok, 0);
    end
    res_ready = 1'b1;
    send(8'd1, 8'd2, 1'b1);
    send(8'd9, 8'd9, 1'b1);
    idle(6);
    res_ready = 1'b0;
    send(8'd2, 8'd2, 1'b1);
    send(8'd3, 8'd3, 1'b0);
    idle(1);
    rst = 1'b0;
    #1;
    for (int k = 0; k < NC; k++) begin
      chk("async_rst_res_valid", k, rv[k], 0);
      chk("async_rst_res_data", k, rd[k], 0);
      chk("async_rst_res_ovf", k, rov[k], 0);
      chk("async_rst_acc_o", k, ac[k], 0);
    end
    idle(2);
    rst = 1'b1;
    res_ready = 1'b1;
    send(8'd3, 8'd4, 1'b1);
    idle(4);
    chk("directed_results", 0, nres, 10);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || ok) begin
        in_valid = ($urandom_range(3) != 0);
        a = 8'($urandom);
        b = 8'($urandom);
        last = ($urandom_range(2) == 0);
      end
      res_ready = ($urandom_range(3) != 0);
      tick(ok);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      tick(ok);
      n++;
    end
    chk("drain_empty", 0, q.size(), 0);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
